div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  divide request from execute stage; sampled only in IDLE.
REQ-004 SHALL have port flush  input  1  pipeline flush (taken branch); aborts any operation.
REQ-005 SHALL have port dividend  input  16  numerator; captured on accepted start.
REQ-006 SHALL have port divisor  input  16  denominator; captured on accepted start.
REQ-007 SHALL have port stall  output  1  hold upstream pipeline stages.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid that cycle.
REQ-010 SHALL have port quotient  output  16  registered quotient.
REQ-011 SHALL have port remainder  output  16  registered remainder.
REQ-012 SHALL have port div_by_zero  output  1  high with done when captured divisor was 0.

Function
REQ-013 SHALL implement states IDLE, LOAD, ITER, FIX, DONE.
REQ-014 SHALL transition IDLE->LOAD when start=1 and flush=0; else stay in IDLE.
REQ-015 SHALL, in LOAD, clear the partial remainder, load the magnitude operands, and set the iteration counter to 15.
REQ-016 SHALL transition LOAD->DONE when divisor=0; otherwise LOAD->ITER.
REQ-017 SHALL perform one restoring shift-subtract step per ITER cycle, 16 steps total; the 4-bit counter decrements to 0, then exits ITER.
REQ-018 SHALL leave ITER for FIX when DIV_SIGNED_EN is defined, otherwise for DONE; FIX SHALL always go to DONE.
REQ-019 SHALL set done=1 for exactly the DONE cycle and return to IDLE the next cycle.
REQ-020 SHALL set unsigned latency as: start accepted at edge N gives done high in cycle N+18, i.e. LOAD 1 + ITER 16 + DONE 1.
REQ-021 SHALL drive stall = (state==IDLE & start & ~flush) | (state in LOAD, ITER, FIX); stall SHALL be low in DONE.
REQ-022 SHALL, on divide-by-zero, produce quotient=16'hFFFF, remainder=dividend, and div_by_zero=1; done SHALL occur 2 cycles after the accepted start.
REQ-023 SHALL ignore start while busy=1; operands SHALL NOT be recaptured.
REQ-024 SHALL, on flush=1 in any state, go to IDLE at the next edge with no done pulse; quotient and remainder SHALL keep their previous values.
REQ-025 SHALL give flush priority over start when both are asserted in the same cycle.
REQ-026 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next DONE.

Reset
REQ-027 SHALL, on rst_n=0, immediately force state=IDLE, counter=0, quotient=0, remainder=0, div_by_zero=0, done=0, busy=0.
REQ-028 SHALL, on reset asserted mid-operation, discard the operation; after release SHALL stay in IDLE until a new start.
REQ-029 SHALL keep stall combinational and low during reset unless start=1 in IDLE with flush=0.

Configuration
REQ-030 SHALL support macro DIV_SIGNED_EN.
REQ-031 SHALL, with DIV_SIGNED_EN defined:
  - treat operands as two's complement;
  - divide magnitudes;
  - negate the quotient in FIX when the operand signs differ;
  - give the remainder the sign of the dividend;
  - result: truncation toward zero; latency 19 cycles.
REQ-032 SHALL, with DIV_SIGNED_EN undefined, be unsigned only, with no FIX state logic and latency 18.
REQ-033 SHALL, in signed mode, for 16'h8000 / 16'hFFFF, produce quotient=16'h8000, remainder=0, div_by_zero=0.

Verification
REQ-034 SHALL check: unsigned 100/7, start at cycle 0 -> done in cycle 18, quotient=14, remainder=2, stall high cycles 0-17.
REQ-035 SHALL check: 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0; then 5/0 -> done 2 cycles after start, quotient=16'hFFFF, remainder=5, div_by_zero=1.
REQ-036 SHALL check: flush at ITER step 8 -> no done pulse, IDLE next cycle, stall low, prior quotient/remainder unchanged.
REQ-037 SHALL check: start re-asserted during ITER with new operands -> ignored, and the original result is delivered.
REQ-038 SHALL check with DIV_SIGNED_EN: -100/7 -> quotient=16'hFFF2 (-14), remainder=16'hFFFE (-2), done in cycle 19.
REQ-039 SHALL check: rst_n pulsed low mid-ITER -> all outputs 0 asynchronously; a new 9/3 start -> quotient=3, remainder=0.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider sequencer: 16-bit operands, one quotient bit per ITER cycle.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIX cycle for sign correction).
module div_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [15:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic        dbz_q, dbz_d, done_q, done_d, busy_q, busy_d;

  logic [16:0] trial;
  logic        ge;
  logic [15:0] step_rem, step_quo, a_mag, b_mag;

  // One restoring step: shift in next dividend bit, subtract divisor if it fits.
  always_comb begin
    trial    = {rem_q, quo_q[15]};
    ge       = (trial >= {1'b0, dvs_q});
    step_rem = ge ? 16'(trial - {1'b0, dvs_q}) : trial[15:0];
    step_quo = {quo_q[14:0], ge};
`ifdef DIV_SIGNED_EN
    a_mag    = a_q[15] ? -a_q : a_q;
    b_mag    = b_q[15] ? -b_q : b_q;
`else
    a_mag    = a_q;
    b_mag    = b_q;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            a_d     = dividend;
            b_d     = divisor;
          end
        end
        S_LOAD: begin
          rem_d = '0;
          quo_d = a_mag;
          dvs_d = b_mag;
          cnt_d = 4'd15;
          if (b_q == 16'd0) begin
            state_d     = S_DONE;
            quotient_d  = 16'hFFFF;
            remainder_d = a_q;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_ITER;
          end
        end
        S_ITER: begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == 4'd0) begin
`ifdef DIV_SIGNED_EN
            state_d = S_FIX;
`else
            state_d     = S_DONE;
            quotient_d  = step_quo;
            remainder_d = step_rem;
            dbz_d       = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
`ifdef DIV_SIGNED_EN
        S_FIX: begin
          // Truncating division: quotient sign from operand signs, remainder follows dividend.
          state_d     = S_DONE;
          quotient_d  = (a_q[15] ^ b_q[15]) ? -quo_q : quo_q;
          remainder_d = a_q[15] ? -rem_q : rem_q;
          dbz_d       = 1'b0;
        end
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign stall = ((state_q == S_IDLE) && start && !flush) ||
                 (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized bench for div_sequencer against an arithmetic reference model.
// Honors DIV_SIGNED_EN the same way as the design build.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [15:0] dividend, divisor;
  logic        stall, busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_q = '0, prev_r = '0;
  logic        prev_dbz = 1'b0;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 18;
`endif

  div_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .dividend(dividend), .divisor(divisor),
    .stall(stall), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic dz);
    int sa, sb, iq, ir;
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = $signed(a); sb = $signed(b);
`else
      sa = int'(a); sb = int'(b);
`endif
      iq = sa / sb;
      ir = sa % sb;
      q = iq[15:0]; r = ir[15:0]; dz = 1'b0;
    end
  endtask

  // Issues one divide in cycle 0 and follows it cycle by cycle until one past done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit restart);
    logic [15:0] eq, er;
    logic        edz;
    int          lat;
    model(a, b, eq, er, edz);
    lat = (b == 16'd0) ? 2 : LAT;
    @(posedge clk); #1;
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    chk("stall_c0", stall, 1);
    chk("done_c0", done, 0);
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (restart && c == 5 && lat > 6) begin
        start = 1'b1; dividend = 16'($urandom); divisor = 16'($urandom);
      end
      @(negedge clk);
      chk("done", done, (c == lat));
      chk("stall", stall, (c < lat));
      chk("busy", busy, (c <= lat));
      if (c == lat || c == lat + 1) begin
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, edz);
      end
    end
    start = 1'b0;
    prev_q = eq; prev_r = er; prev_dbz = edz;
  endtask

  initial begin
    int npulse;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; dividend = '0; divisor = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_stall_idle", stall, 0);
    start = 1'b1; #1;
    chk("rst_stall_start", stall, 1);
    flush = 1'b1; #1;
    chk("rst_stall_flush", stall, 0);
    start = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(16'd100, 16'd7, 1'b0);
    run_op(16'hFFFF, 16'd1, 1'b0);
    run_op(16'd5, 16'd0, 1'b0);
    run_op(16'hFF9C, 16'd7, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0);
    run_op(16'd1234, 16'd56, 1'b1);

    // Flush during the 8th ITER step (cycle 9): no done, IDLE next cycle, results held.
    @(posedge clk); #1;
    dividend = 16'd4321; divisor = 16'd9; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_stall", stall, 0);
    chk("flush_done", done, 0);
    chk("flush_quotient", quotient, prev_q);
    chk("flush_remainder", remainder, prev_r);
    chk("flush_dbz", div_by_zero, prev_dbz);
    npulse = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("flush_no_done", npulse, 0);

    // Flush wins over start in IDLE.
    @(posedge clk); #1;
    dividend = 16'd50; divisor = 16'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("prio_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("prio_busy", busy, 0);

    // Asynchronous reset mid-ITER.
    @(posedge clk); #1;
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_quotient", quotient, 0);
    chk("arst_remainder", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    chk("arst_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    npulse = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy || done) npulse++;
    end
    chk("arst_idle", npulse, 0);
    run_op(16'd9, 16'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      run_op(a, b, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
